// File: rtl/load_store_queue.sv
// load_store_queue: in-order load/store queue between the LSB reservation
// station and the memory controller.
// Ready memory ops arrive with resolved operands. The queue computes each
// effective address, issues accesses one at a time from the head, and
// broadcasts load results and store-address notices on the LSB CDB.
// A store only writes memory after the ROB commits it.
// Optional feature: define LSQ_PERF_CNT_EN to add the perf_load_cnt and
// perf_store_cnt completion counters and their ports.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | inspect head: issue load, announce store, or issue commit
// WAIT_MEM | request held on the bus until mem_done, then pop the head
// DRAIN    | flushed load still in flight; swallow its data, no pop/CDB
module load_store_queue #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              LSB_valid,
    input  logic [OP_W-1:0]   LSB_op,
    input  logic [DATA_W-1:0] LSB_reg1,
    input  logic [DATA_W-1:0] LSB_reg2,
    input  logic [DATA_W-1:0] LSB_imm,
    input  logic [TAG_W-1:0]  LSB_reg_des_rob,
    output logic              LSB_is_full,
    input  logic              rob_commit_valid,
    input  logic [TAG_W-1:0]  rob_commit_tag,
    output logic              mem_req_valid,
    output logic              mem_req_we,
    output logic [DATA_W-1:0] mem_req_addr,
    output logic [1:0]        mem_req_size,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              LSB_cdb_valid,
    output logic [TAG_W-1:0]  LSB_cdb_tag,
    output logic [DATA_W-1:0] LSB_cdb_data
`ifdef LSQ_PERF_CNT_EN
    ,
    output logic [31:0]       perf_load_cnt,
    output logic [31:0]       perf_store_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] FULL_THR = CNT_W'(DEPTH - 2);

    // Memory opcode encodings shared with the decoder.
    localparam logic [OP_W-1:0] OP_LB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LH  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LW  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_LBU = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LHU = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SB  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SH  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(8);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_DRAIN    = 2'd2
    } state_t;

    function automatic logic op_is_store(input logic [OP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [1:0] op_size(input logic [OP_W-1:0] op);
        logic [1:0] sz;
        sz = 2'd2;
        if (op == OP_LB || op == OP_LBU || op == OP_SB) begin
            sz = 2'd0;
        end else if (op == OP_LH || op == OP_LHU || op == OP_SH) begin
            sz = 2'd1;
        end
        return sz;
    endfunction

    function automatic logic [DATA_W-1:0] load_ext(input logic [OP_W-1:0]   op,
                                                   input logic [DATA_W-1:0] raw);
        logic [DATA_W-1:0] val;
        val = raw;
        if (op == OP_LB) begin
            val = {{(DATA_W-8){raw[7]}}, raw[7:0]};
        end else if (op == OP_LBU) begin
            val = {{(DATA_W-8){1'b0}}, raw[7:0]};
        end else if (op == OP_LH) begin
            val = {{(DATA_W-16){raw[15]}}, raw[15:0]};
        end else if (op == OP_LHU) begin
            val = {{(DATA_W-16){1'b0}}, raw[15:0]};
        end
        return val;
    endfunction

    // Queue storage
    logic [OP_W-1:0]   ent_op    [DEPTH];
    logic [DATA_W-1:0] ent_addr  [DEPTH];
    logic [DATA_W-1:0] ent_wdata [DEPTH];
    logic [TAG_W-1:0]  ent_tag   [DEPTH];
    logic              ent_valid [DEPTH];
    logic              ent_com   [DEPTH];
    logic              ent_ann   [DEPTH];

    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [CNT_W-1:0]  count;
    state_t            state;

    logic head_valid;
    logic head_store;
    logic head_com;
    logic head_ann;
    logic do_enq;
    logic do_pop;
    logic idle_act;
    logic announce_now;
    logic issue_now;
    logic commit_hit;
    logic keep_head;

    assign head_valid = ent_valid[head_ptr];
    assign head_store = op_is_store(ent_op[head_ptr]);
    assign head_com   = ent_com[head_ptr];
    assign head_ann   = ent_ann[head_ptr];

    // An issue arriving while the queue is full is dropped; the RS is
    // expected to have stalled on LSB_is_full two slots earlier.
    assign do_enq = rdy && LSB_valid && !clear && (count != CNT_MAX);
    assign do_pop = rdy && (state == S_WAIT_MEM) && mem_done;

    // Head decisions are skipped on a flush cycle; a kept committed store
    // is picked up on the following cycle.
    assign idle_act     = rdy && (state == S_IDLE) && !clear && head_valid;
    assign announce_now = idle_act && head_store && !head_ann;
    assign issue_now    = idle_act && (!head_store || (head_com && head_ann));

    assign commit_hit = rdy && !clear && rob_commit_valid && head_valid &&
                        head_store && (ent_tag[head_ptr] == rob_commit_tag);

    // A committed store is architecturally retired and must survive a flush
    // unless it is completing in this very cycle.
    assign keep_head = clear && head_valid && head_store && head_com && !do_pop;

    assign LSB_is_full = (count >= FULL_THR);

    // Entry payload is captured at the tail on enqueue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_op[i]    <= '0;
                ent_addr[i]  <= '0;
                ent_wdata[i] <= '0;
                ent_tag[i]   <= '0;
            end
        end else if (do_enq) begin
            ent_op[tail_ptr]    <= LSB_op;
            ent_addr[tail_ptr]  <= LSB_reg1 + LSB_imm;
            ent_wdata[tail_ptr] <= LSB_reg2;
            ent_tag[tail_ptr]   <= LSB_reg_des_rob;
        end
    end

    // Pointers, occupancy and per-entry status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_valid[i] <= 1'b0;
                ent_com[i]   <= 1'b0;
                ent_ann[i]   <= 1'b0;
            end
        end else if (rdy) begin
            if (clear) begin
                for (int i = 0; i < DEPTH; i++) begin
                    ent_valid[i] <= 1'b0;
                end
                if (do_pop) begin
                    head_ptr <= head_ptr + 1'b1;
                    tail_ptr <= head_ptr + 1'b1;
                    count    <= '0;
                end else if (keep_head) begin
                    ent_valid[head_ptr] <= 1'b1;
                    tail_ptr <= head_ptr + 1'b1;
                    count    <= CNT_W'(1);
                end else begin
                    tail_ptr <= head_ptr;
                    count    <= '0;
                end
            end else begin
                if (do_enq) begin
                    ent_valid[tail_ptr] <= 1'b1;
                    ent_com[tail_ptr]   <= 1'b0;
                    ent_ann[tail_ptr]   <= 1'b0;
                    tail_ptr <= tail_ptr + 1'b1;
                end
                if (do_pop) begin
                    ent_valid[head_ptr] <= 1'b0;
                    head_ptr <= head_ptr + 1'b1;
                end
                if (announce_now) begin
                    ent_ann[head_ptr] <= 1'b1;
                end
                if (commit_hit) begin
                    ent_com[head_ptr] <= 1'b1;
                end
                count <= count + CNT_W'(do_enq) - CNT_W'(do_pop);
            end
        end
    end

    // Access FSM with registered memory request and CDB outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_size  <= 2'd0;
            mem_req_wdata <= '0;
            LSB_cdb_valid <= 1'b0;
            LSB_cdb_tag   <= '0;
            LSB_cdb_data  <= '0;
        end else if (rdy) begin
            LSB_cdb_valid <= 1'b0;
            LSB_cdb_tag   <= '0;
            LSB_cdb_data  <= '0;
            case (state)
                S_IDLE: begin
                    if (issue_now) begin
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= head_store;
                        mem_req_addr  <= ent_addr[head_ptr];
                        mem_req_size  <= op_size(ent_op[head_ptr]);
                        mem_req_wdata <= head_store ? ent_wdata[head_ptr] : '0;
                        state         <= S_WAIT_MEM;
                    end else if (announce_now) begin
                        LSB_cdb_valid <= 1'b1;
                        LSB_cdb_tag   <= ent_tag[head_ptr];
                    end
                end
                S_WAIT_MEM: begin
                    if (mem_done) begin
                        mem_req_valid <= 1'b0;
                        mem_req_we    <= 1'b0;
                        mem_req_addr  <= '0;
                        mem_req_size  <= 2'd0;
                        mem_req_wdata <= '0;
                        state         <= S_IDLE;
                        if (!mem_req_we && !clear) begin
                            LSB_cdb_valid <= 1'b1;
                            LSB_cdb_tag   <= ent_tag[head_ptr];
                            LSB_cdb_data  <= load_ext(ent_op[head_ptr], mem_rdata);
                        end
                    end else if (clear && !mem_req_we) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (mem_done) begin
                        mem_req_valid <= 1'b0;
                        mem_req_we    <= 1'b0;
                        mem_req_addr  <= '0;
                        mem_req_size  <= 2'd0;
                        mem_req_wdata <= '0;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LSQ_PERF_CNT_EN
    // Completed accesses by type, including drained loads; not flushed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_load_cnt  <= '0;
            perf_store_cnt <= '0;
        end else if (rdy && mem_done && (state == S_WAIT_MEM || state == S_DRAIN)) begin
            if (mem_req_we) begin
                perf_store_cnt <= perf_store_cnt + 32'd1;
            end else begin
                perf_load_cnt <= perf_load_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: a vector table of single memory ops
// followed by hand-written fill/wrap, flush and drain sequences.
module tb_load_store_queue;

    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LH  = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd3;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_LHU = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        LSB_valid;
    logic [5:0]  LSB_op;
    logic [31:0] LSB_reg1;
    logic [31:0] LSB_reg2;
    logic [31:0] LSB_imm;
    logic [3:0]  LSB_reg_des_rob;
    logic        LSB_is_full;
    logic        rob_commit_valid;
    logic [3:0]  rob_commit_tag;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [1:0]  mem_req_size;
    logic [31:0] mem_req_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        LSB_cdb_valid;
    logic [3:0]  LSB_cdb_tag;
    logic [31:0] LSB_cdb_data;
`ifdef LSQ_PERF_CNT_EN
    logic [31:0] perf_load_cnt;
    logic [31:0] perf_store_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cdb_cnt  = 0;

    load_store_queue #(.DEPTH(16), .DATA_W(32), .TAG_W(4), .OP_W(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .clear            (clear),
        .LSB_valid        (LSB_valid),
        .LSB_op           (LSB_op),
        .LSB_reg1         (LSB_reg1),
        .LSB_reg2         (LSB_reg2),
        .LSB_imm          (LSB_imm),
        .LSB_reg_des_rob  (LSB_reg_des_rob),
        .LSB_is_full      (LSB_is_full),
        .rob_commit_valid (rob_commit_valid),
        .rob_commit_tag   (rob_commit_tag),
        .mem_req_valid    (mem_req_valid),
        .mem_req_we       (mem_req_we),
        .mem_req_addr     (mem_req_addr),
        .mem_req_size     (mem_req_size),
        .mem_req_wdata    (mem_req_wdata),
        .mem_done         (mem_done),
        .mem_rdata        (mem_rdata),
        .LSB_cdb_valid    (LSB_cdb_valid),
        .LSB_cdb_tag      (LSB_cdb_tag),
        .LSB_cdb_data     (LSB_cdb_data)
`ifdef LSQ_PERF_CNT_EN
        ,
        .perf_load_cnt    (perf_load_cnt),
        .perf_store_cnt   (perf_store_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (LSB_cdb_valid) cdb_cnt++;
    end

    always @(posedge clk) begin
        if (rst && rdy && LSB_valid && !clear)
            assert (dut.count != 5'd16) else $error("enqueue while queue full");
    end

    typedef struct {
        logic [5:0]  op;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [31:0] imm;
        logic [3:0]  tag;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [1:0]  exp_size;
        logic [31:0] exp_val;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] imm, input logic [3:0] tag);
        LSB_valid = 1'b1;
        LSB_op = op;
        LSB_reg1 = r1;
        LSB_reg2 = r2;
        LSB_imm = imm;
        LSB_reg_des_rob = tag;
        tick();
        LSB_valid = 1'b0;
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 40 && !mem_req_valid; i++) tick();
        check({name, " req_wait"}, {31'd0, mem_req_valid}, 32'd1);
    endtask

    task automatic wait_cdb(input string name);
        for (int i = 0; i < 40 && !LSB_cdb_valid; i++) tick();
        check({name, " cdb_wait"}, {31'd0, LSB_cdb_valid}, 32'd1);
    endtask

    task automatic mem_pulse(input logic [31:0] rd);
        mem_done = 1'b1;
        mem_rdata = rd;
        tick();
        mem_done = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic commit(input logic [3:0] tag);
        rob_commit_valid = 1'b1;
        rob_commit_tag = tag;
        tick();
        rob_commit_valid = 1'b0;
        rob_commit_tag = '0;
    endtask

    initial begin
        vec_t t;
        int   base;
        int   nxt;
        int   seen_req;

        vecs[0] = '{OP_LW,  32'h0000_1000, 32'h0, 32'h4,         4'd3, 32'h8000_0001, 32'h0000_1004, 2'd2, 32'h8000_0001};
        vecs[1] = '{OP_LB,  32'h0000_2000, 32'h0, 32'h1,         4'd1, 32'h0000_00F0, 32'h0000_2001, 2'd0, 32'hFFFF_FFF0};
        vecs[2] = '{OP_LBU, 32'h0000_2000, 32'h0, 32'h1,         4'd2, 32'h0000_00F0, 32'h0000_2001, 2'd0, 32'h0000_00F0};
        vecs[3] = '{OP_LH,  32'h0000_0100, 32'h0, 32'hFFFF_FFFE, 4'd4, 32'h1234_8001, 32'h0000_00FE, 2'd1, 32'hFFFF_8001};
        vecs[4] = '{OP_LHU, 32'h0000_0100, 32'h0, 32'hFFFF_FFFE, 4'd6, 32'h1234_8001, 32'h0000_00FE, 2'd1, 32'h0000_8001};
        vecs[5] = '{OP_SW,  32'h0000_0020, 32'hDEAD_BEEF, 32'h10, 4'd5, 32'h0, 32'h0000_0030, 2'd2, 32'hDEAD_BEEF};
        vecs[6] = '{OP_SB,  32'h0000_0040, 32'h0000_00AB, 32'h3,  4'd7, 32'h0, 32'h0000_0043, 2'd0, 32'h0000_00AB};
        vecs[7] = '{OP_SH,  32'h0000_0050, 32'h0000_1234, 32'h0,  4'd8, 32'h0, 32'h0000_0050, 2'd1, 32'h0000_1234};
        vecs[8] = '{OP_LB,  32'hFFFF_FFFF, 32'h0, 32'h2,         4'd9, 32'h0000_007F, 32'h0000_0001, 2'd0, 32'h0000_007F};

        rst = 1'b0; rdy = 1'b1; clear = 1'b0; LSB_valid = 1'b0; LSB_op = '0;
        LSB_reg1 = '0; LSB_reg2 = '0; LSB_imm = '0; LSB_reg_des_rob = '0;
        rob_commit_valid = 1'b0; rob_commit_tag = '0; mem_done = 1'b0; mem_rdata = '0;
        repeat (3) tick();

        check("rst req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("rst req_addr",  mem_req_addr, 32'd0);
        check("rst cdb_valid", {31'd0, LSB_cdb_valid}, 32'd0);
        check("rst cdb_data",  LSB_cdb_data, 32'd0);
        check("rst is_full",   {31'd0, LSB_is_full}, 32'd0);
        rst = 1'b1;
        tick();

        // single-op vector table
        for (int v = 0; v < 9; v++) begin
            t = vecs[v];
            issue(t.op, t.reg1, t.reg2, t.imm, t.tag);
            if (t.op == OP_SB || t.op == OP_SH || t.op == OP_SW) begin
                wait_cdb($sformatf("v%0d notice", v));
                check($sformatf("v%0d notice tag", v), {28'd0, LSB_cdb_tag}, {28'd0, t.tag});
                check($sformatf("v%0d notice data", v), LSB_cdb_data, 32'd0);
                repeat (3) tick();
                check($sformatf("v%0d no req before commit", v), {31'd0, mem_req_valid}, 32'd0);
                commit(t.tag + 4'd1);
                repeat (2) tick();
                check($sformatf("v%0d wrong tag ignored", v), {31'd0, mem_req_valid}, 32'd0);
                commit(t.tag);
                wait_req($sformatf("v%0d", v));
                check($sformatf("v%0d we", v),    {31'd0, mem_req_we}, 32'd1);
                check($sformatf("v%0d addr", v),  mem_req_addr, t.exp_addr);
                check($sformatf("v%0d size", v),  {30'd0, mem_req_size}, {30'd0, t.exp_size});
                check($sformatf("v%0d wdata", v), mem_req_wdata, t.exp_val);
                mem_pulse(32'hFFFF_FFFF);
                check($sformatf("v%0d no cdb after write", v), {31'd0, LSB_cdb_valid}, 32'd0);
            end else begin
                wait_req($sformatf("v%0d", v));
                check($sformatf("v%0d we", v),   {31'd0, mem_req_we}, 32'd0);
                check($sformatf("v%0d addr", v), mem_req_addr, t.exp_addr);
                check($sformatf("v%0d size", v), {30'd0, mem_req_size}, {30'd0, t.exp_size});
                mem_pulse(t.rdata);
                check($sformatf("v%0d req dropped", v), {31'd0, mem_req_valid}, 32'd0);
                wait_cdb($sformatf("v%0d", v));
                check($sformatf("v%0d cdb tag", v),  {28'd0, LSB_cdb_tag}, {28'd0, t.tag});
                check($sformatf("v%0d cdb data", v), LSB_cdb_data, t.exp_val);
            end
            tick();
        end

        // frozen by rdy=0: issue ignored
        rdy = 1'b0;
        issue(OP_LW, 32'h500, 32'h0, 32'h0, 4'd0);
        rdy = 1'b1;
        repeat (4) tick();
        check("rdy freeze no req", {31'd0, mem_req_valid}, 32'd0);

        // fill to 14, drain one, then wrap with enqueue+pop overlap
        for (int k = 0; k < 14; k++) begin
            issue(OP_LW, 32'h1000, 32'h0, 32'(4 * k), 4'(k));
            if (k == 12) check("13 entries not full", {31'd0, LSB_is_full}, 32'd0);
        end
        check("14 entries full", {31'd0, LSB_is_full}, 32'd1);
        nxt = 14;
        for (int s = 0; s < 20; s++) begin
            wait_req($sformatf("wrap%0d", s));
            check($sformatf("wrap%0d addr", s), mem_req_addr, 32'h1000 + 32'(4 * s));
            if (s > 0 && nxt < 20) begin
                LSB_valid = 1'b1; LSB_op = OP_LW; LSB_reg1 = 32'h1000;
                LSB_imm = 32'(4 * nxt); LSB_reg2 = '0; LSB_reg_des_rob = 4'(nxt);
                nxt++;
            end
            mem_pulse(32'hA000 + 32'(s));
            LSB_valid = 1'b0;
            if (s == 0) check("drain one not full", {31'd0, LSB_is_full}, 32'd0);
            wait_cdb($sformatf("wrap%0d", s));
            check($sformatf("wrap%0d tag", s),  {28'd0, LSB_cdb_tag}, 32'(s % 16));
            check($sformatf("wrap%0d data", s), LSB_cdb_data, 32'hA000 + 32'(s));
        end
        repeat (3) tick();
        check("wrap done no req", {31'd0, mem_req_valid}, 32'd0);

        // committed store at head survives flush; queued loads vanish
        issue(OP_SW, 32'h60, 32'hCAFE_F00D, 32'h0, 4'd9);
        wait_cdb("flush notice");
        check("flush notice tag", {28'd0, LSB_cdb_tag}, 32'd9);
        tick();
        issue(OP_LW, 32'h80, 32'h0, 32'h0, 4'd10);
        issue(OP_LW, 32'h84, 32'h0, 32'h0, 4'd11);
        issue(OP_LW, 32'h88, 32'h0, 32'h0, 4'd12);
        commit(4'd9);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        base = cdb_cnt;
        wait_req("flush store");
        check("flush we",    {31'd0, mem_req_we}, 32'd1);
        check("flush addr",  mem_req_addr, 32'h60);
        check("flush wdata", mem_req_wdata, 32'hCAFE_F00D);
        mem_pulse(32'h0);
        seen_req = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_req_valid) seen_req++;
        end
        check("flush loads dropped", 32'(seen_req), 32'd0);
        check("flush no cdb", 32'(cdb_cnt - base), 32'd0);
        check("flush empty not full", {31'd0, LSB_is_full}, 32'd0);

        // flush during an in-flight load
        issue(OP_LW, 32'h70, 32'h0, 32'h0, 4'd13);
        wait_req("drain");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        base = cdb_cnt;
        repeat (2) tick();
        check("drain req held", {31'd0, mem_req_valid}, 32'd1);
        check("drain addr held", mem_req_addr, 32'h70);
        mem_pulse(32'h55);
        repeat (5) tick();
        check("drain no cdb", 32'(cdb_cnt - base), 32'd0);
        check("drain req released", {31'd0, mem_req_valid}, 32'd0);
        issue(OP_LW, 32'h74, 32'h0, 32'h0, 4'd14);
        wait_req("post drain");
        check("post drain addr", mem_req_addr, 32'h74);
        mem_pulse(32'h1122_3344);
        wait_cdb("post drain");
        check("post drain tag", {28'd0, LSB_cdb_tag}, 32'd14);
        check("post drain data", LSB_cdb_data, 32'h1122_3344);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
